// File: rtl/sad_ssd_cost_pipe.sv
// Pipelined SAD/SSD matching cost over two CNTX_SIZE x CNTX_SIZE windows.
// Ports: clk, rst (async high), ready (advance enable), i_kernel1_data /
//   i_kernel2_data (packed windows), i_kernels_valid, i_mode (0 SAD, 1 SSD),
//   i_clear_stats; o_cost_data (saturated cost), o_cost_valid, o_sat_count.
module sad_ssd_cost_pipe #(
    parameter int CNTX_SIZE  = 3,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 8,
    parameter int CNT_WIDTH  = 16,
    localparam int N     = CNTX_SIZE * CNTX_SIZE,
    localparam int LVL   = $clog2(N),
    localparam int SUM_W = 2 * DATA_WIDTH + LVL
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ready,
    input  logic [N*DATA_WIDTH-1:0] i_kernel1_data,
    input  logic [N*DATA_WIDTH-1:0] i_kernel2_data,
    input  logic                    i_kernels_valid,
    input  logic                    i_mode,
    input  logic                    i_clear_stats,
    output logic [OUT_WIDTH-1:0]    o_cost_data,
    output logic                    o_cost_valid,
    output logic [CNT_WIDTH-1:0]    o_sat_count
);

    localparam logic [SUM_W-1:0] OUT_MAX =
        {SUM_W{1'b1}} >> (SUM_W - OUT_WIDTH);

    // Number of live terms at tree level l (level 0 = per-pixel terms).
    function automatic int lvl_cnt(input int l);
        int c;
        c = N;
        for (int k = 0; k < l; k++) c = (c + 1) / 2;
        return c;
    endfunction

    // Clamp an index into the array; out-of-range slots are never used.
    function automatic int idx(input int j);
        return (j < N) ? j : 0;
    endfunction

    logic [2*DATA_WIDTH-1:0] term [N];
    logic [SUM_W-1:0]        tree [LVL+1][N];
    logic [LVL:0]            vld;
    logic [SUM_W-1:0]        sum;
    logic                    sat;

    always_comb begin
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic [DATA_WIDTH-1:0] d;
        for (int i = 0; i < N; i++) begin
            a = i_kernel1_data[i*DATA_WIDTH +: DATA_WIDTH];
            b = i_kernel2_data[i*DATA_WIDTH +: DATA_WIDTH];
            d = (a > b) ? a - b : b - a;
            if (i_mode) term[i] = d * d;
            else        term[i] = {{DATA_WIDTH{1'b0}}, d};
        end
    end

    assign sum = tree[LVL][0];
    assign sat = sum > OUT_MAX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l <= LVL; l++)
                for (int i = 0; i < N; i++)
                    tree[l][i] <= '0;
            vld          <= '0;
            o_cost_data  <= '1;
            o_cost_valid <= 1'b0;
        end else if (ready) begin
            for (int i = 0; i < N; i++)
                tree[0][i] <= SUM_W'(term[i]);
            vld[0] <= i_kernels_valid;
            for (int l = 1; l <= LVL; l++) begin
                vld[l] <= vld[l-1];
                for (int i = 0; i < N; i++) begin
                    if (i >= lvl_cnt(l))
                        tree[l][i] <= '0;
                    else if (2*i + 1 < lvl_cnt(l-1))
                        tree[l][i] <= tree[l-1][idx(2*i)]
                                    + tree[l-1][idx(2*i+1)];
                    else
                        tree[l][i] <= tree[l-1][idx(2*i)];
                end
            end
            if (!vld[LVL]) begin
                o_cost_data  <= '1;
                o_cost_valid <= 1'b0;
            end else begin
                o_cost_data  <= sat ? '1 : sum[OUT_WIDTH-1:0];
                o_cost_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            o_sat_count <= '0;
        else if (i_clear_stats)
            o_sat_count <= '0;
        else if (ready && vld[LVL] && sat && o_sat_count != '1)
            o_sat_count <= o_sat_count + 1'b1;
    end

endmodule

// File: tb/tb_sad_ssd_cost_pipe.sv
// Directed self-checking bench for sad_ssd_cost_pipe (3x3, 8-bit).
// Each scenario task drives vectors and checks hand-computed results.
module tb_sad_ssd_cost_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b1;
    logic [71:0] k1 = '0;
    logic [71:0] k2 = '0;
    logic        kv = 1'b0;
    logic        mode = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  cost;
    logic        cval;
    logic [15:0] scnt;

    int checks = 0;
    int failures = 0;

    sad_ssd_cost_pipe dut (
        .clk            (clk),
        .rst            (rst),
        .ready          (ready),
        .i_kernel1_data (k1),
        .i_kernel2_data (k2),
        .i_kernels_valid(kv),
        .i_mode         (mode),
        .i_clear_stats  (clr),
        .o_cost_data    (cost),
        .o_cost_valid   (cval),
        .o_sat_count    (scnt)
    );

    always #5 clk = ~clk;

    function automatic logic [71:0] fill(input logic [7:0] v);
        logic [71:0] f;
        for (int i = 0; i < 9; i++) f[i*8 +: 8] = v;
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic test_reset();
        logic [95:0] r;
        r = {$urandom(), $urandom(), $urandom()};
        k1 = r[71:0];
        r = {$urandom(), $urandom(), $urandom()};
        k2 = r[71:0];
        kv = 1'b1;
        ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_cost", int'(cost), 255);
        chk("rst_valid", int'(cval), 0);
        chk("rst_cnt", int'(scnt), 0);
        tick();
        tick();
        chk("rst_hold_cost", int'(cost), 255);
        chk("rst_hold_valid", int'(cval), 0);
        chk("rst_hold_cnt", int'(scnt), 0);
        kv = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_sad();
        k1 = fill(8'd10);
        k2 = fill(8'd7);
        kv = 1'b1;
        mode = 1'b0;
        tick();
        kv = 1'b0;
        repeat (4) tick();
        chk("sad_early_valid", int'(cval), 0);
        tick();
        chk("sad_cost", int'(cost), 27);
        chk("sad_valid", int'(cval), 1);
        tick();
        chk("sad_after_cost", int'(cost), 255);
        chk("sad_after_valid", int'(cval), 0);
    endtask

    task automatic test_saturation();
        k1 = fill(8'd255);
        k2 = fill(8'd0);
        kv = 1'b1;
        mode = 1'b0;
        tick();
        kv = 1'b0;
        repeat (5) tick();
        chk("sat_cost", int'(cost), 255);
        chk("sat_valid", int'(cval), 1);
        chk("sat_cnt", int'(scnt), 1);
        kv = 1'b1;
        tick();
        kv = 1'b0;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("sat2_valid", int'(cval), 1);
        chk("sat2_clear_wins", int'(scnt), 0);
    endtask

    task automatic test_mode_switch();
        k1 = fill(8'd3);
        k2 = fill(8'd1);
        kv = 1'b1;
        mode = 1'b0;
        tick();
        mode = 1'b1;
        tick();
        kv = 1'b0;
        mode = 1'b0;
        repeat (4) tick();
        chk("mode_sad", int'(cost), 18);
        chk("mode_sad_valid", int'(cval), 1);
        tick();
        chk("mode_ssd", int'(cost), 36);
        chk("mode_ssd_valid", int'(cval), 1);
        k1 = fill(8'd5);
        k2 = fill(8'd5);
        k1[7:0] = 8'd17;
        k2[7:0] = 8'd0;
        kv = 1'b1;
        mode = 1'b1;
        tick();
        kv = 1'b0;
        mode = 1'b0;
        repeat (5) tick();
        chk("ssd_sat_cost", int'(cost), 255);
        chk("ssd_sat_valid", int'(cval), 1);
        chk("ssd_sat_cnt", int'(scnt), 1);
    endtask

    task automatic test_stall();
        int vals [17] = '{1, 2, 9, 9, 9, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        bit rdys [17] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int got [$];
        int frz;
        logic [7:0] pc;
        logic pv;
        frz = 0;
        k2 = '0;
        mode = 1'b0;
        for (int c = 0; c < 17; c++) begin
            k1 = '0;
            k1[7:0] = 8'(vals[c]);
            kv = (vals[c] != 0);
            ready = rdys[c];
            pc = cost;
            pv = cval;
            tick();
            if (!rdys[c] && (cost !== pc || cval !== pv)) frz++;
            if (rdys[c] && cval) got.push_back(int'(cost));
        end
        ready = 1'b1;
        kv = 1'b0;
        chk("stall_frozen_errs", frz, 0);
        chk("stall_count", got.size(), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("stall_out%0d", i),
                (i < got.size()) ? got[i] : -1, i + 1);
    endtask

    task automatic test_midreset();
        int seen;
        k1 = fill(8'd4);
        k2 = fill(8'd2);
        kv = 1'b1;
        mode = 1'b0;
        repeat (5) tick();
        kv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_cost", int'(cost), 255);
        chk("mrst_valid", int'(cval), 0);
        chk("mrst_cnt", int'(scnt), 0);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            if (cval) seen++;
        end
        chk("mrst_no_valid", seen, 0);
    endtask

    initial begin
        test_reset();
        test_sad();
        test_saturation();
        test_mode_switch();
        test_stall();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sad_ssd_cost_pipe.md
Name: sad_ssd_cost_pipe

Overview:
Parametrised, fully pipelined matching-cost unit for the stereovision datapath. It compares two CNTX_SIZE x CNTX_SIZE pixel windows and produces either their sum of absolute differences (SAD) or their sum of squared differences (SSD), selected per sample. The result is saturated to OUT_WIDTH and carries a valid flag. The block stalls under a global ready enable and keeps a running count of saturated results for tuning. It sits between the window generators and the disparity winner-take-all stage.

Parameters:
CNTX_SIZE, 3, window edge length in pixels (>=2); the window has N = CNTX_SIZE*CNTX_SIZE terms.
DATA_WIDTH, 8, pixel width in bits.
OUT_WIDTH, 8, cost output width in bits (1..SUM_W).
CNT_WIDTH, 16, width of the saturation counter.
Derived: LVL = clog2(N); SUM_W = 2*DATA_WIDTH + LVL; LAT = LVL + 2.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  reset.
ready  in  1  pipeline enable; 0 = freeze every pipeline register.
i_kernel1_data  in  N*DATA_WIDTH  left window; element [i][j] sits at bits (i*CNTX_SIZE+j)*DATA_WIDTH +: DATA_WIDTH.
i_kernel2_data  in  N*DATA_WIDTH  right window, same packing.
i_kernels_valid  in  1  both windows valid this cycle.
i_mode  in  1  0 = SAD, 1 = SSD; sampled together with the windows.
i_clear_stats  in  1  synchronous clear of o_sat_count.
o_cost_data  out  OUT_WIDTH  cost, saturated; all-ones when not valid.
o_cost_valid  out  1  o_cost_data is a real cost.
o_sat_count  out  CNT_WIDTH  number of valid outputs that saturated.

Interface (already decided): one clock; reset is asynchronous and active-high.

Behaviour:
- Reset (async, active-high): all pipeline data registers and valid bits go to 0; o_cost_data = all-ones; o_cost_valid = 0; o_sat_count = 0. Deassertion takes effect on the next clk edge.
- Pipeline advance: all stages advance only on edges where ready=1. With ready=0, every stage register, including valid and mode, holds its value and outputs hold. No sample is lost or duplicated.
- Stage 0 (register): per element, d = |k1-k2| (DATA_WIDTH bits).
  - SAD mode: term = d, zero-extended to 2*DATA_WIDTH.
  - SSD mode: term = d*d (2*DATA_WIDTH bits).
  - The stage also registers the valid and mode bits.
- Stages 1..LVL (adder tree, one register per level):
  - Each level adds pairs of the previous level's terms, growing width by 1 bit.
  - An odd leftover term passes through a register unchanged.
  - The final sum is SUM_W bits and cannot overflow.
- Output stage (register):
  - If valid=0: o_cost_data = all-ones and o_cost_valid = 0.
  - Else if sum >= 2^OUT_WIDTH: o_cost_data = all-ones, o_cost_valid = 1, and this is a saturation event.
  - Else: o_cost_data = sum[OUT_WIDTH-1:0] and o_cost_valid = 1.
- Latency: a sample accepted on advancing edge k appears on outputs after advancing edge k+LAT-1, i.e. LAT advancing edges including the capture edge. For CNTX_SIZE=3: LAT = 6. Throughput is one sample per advancing cycle.
- Mode is per-sample and travels with its data. Switching i_mode between consecutive samples affects only the later sample; no bubble is inserted.
- o_sat_count:
  - Increments by 1 on each output-stage update that is a saturation event.
  - Sticks at all-ones and does not wrap.
  - i_clear_stats=1 clears it to 0 on the edge, regardless of ready. Clear wins over a simultaneous increment.
- Invalid samples never touch o_sat_count.
- Async reset mid-stream flushes the whole pipeline. No valid output appears until new valid inputs have propagated LAT advancing edges.

Test Plan:
1. Assert rst with random inputs and ready=1 -> immediately o_cost_data=8'hFF, o_cost_valid=0, o_sat_count=0, held while rst=1.
2. SAD: k1 all 10, k2 all 7, valid=1, mode=0, single cycle -> exactly 6 edges later o_cost_data=27, o_cost_valid=1 for one cycle; then 8'hFF with valid=0.
3. Saturation: SAD with k1 all 255, k2 all 0 (sum 2295) -> o_cost_data=8'hFF, o_cost_valid=1, o_sat_count=1. Repeat with i_clear_stats=1 on the same edge as the second saturation -> o_sat_count=0.
4. Mode switching: back-to-back samples with k1 all 3, k2 all 1, mode 0 then 1 -> consecutive outputs 18 then 36, both valid. Also k1[0][0]=17, rest equal, SSD -> 8'hFF saturated (289 > 255).
5. Stall: stream 4 samples with SAD results 1, 2, 3, 4 and drop ready for 3 cycles after the second -> outputs and valid frozen during the stall; results 1, 2, 3, 4 emerge in order, none repeated or lost.
6. Mid-stream reset: 5 valid samples in flight, pulse rst for one cycle between edges -> outputs clear asynchronously; no o_cost_valid=1 appears for at least 6 advancing edges after release unless new valid input is applied.
